// File: rtl/enpc_if.sv
// Run-enable / PC-load-enable pair between the core sequencer and the PC register.
// The core (master) drives the run enable; enpc (slave) returns the PC load enable.
interface enpc_if;
  logic en;
  logic set_en;

  modport master (output en, input set_en);
  modport slave  (input en, output set_en);
endinterface

// File: rtl/enpc.sv
// PC set-enable generator: steps each instruction through PHASES clock phases
// and flags the last phase so the PC register loads its next value.
module enpc #(
  parameter int PHASES = 5,
  parameter int PW     = (PHASES > 1) ? $clog2(PHASES) : 1
) (
  input  logic  i_clock,
  input  logic  i_reset_n,
  enpc_if.slave bus
);

  localparam logic [PW-1:0] LAST = PW'(PHASES - 1);

  if (PHASES < 1 || PHASES > 16) begin : g_bad_phases
    $error("enpc: PHASES must be within 1..16");
  end

  logic [PW-1:0] r_phase;
  logic          w_last;

  // Values above LAST are unreachable in normal operation; the >= folds them back to 0.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_phase <= '0;
    end else if (bus.en) begin
      r_phase <= (r_phase >= LAST) ? '0 : r_phase + PW'(1);
    end
  end

  assign w_last     = (r_phase == LAST);
  assign bus.set_en = i_reset_n & bus.en & w_last;

endmodule

// File: tb/tb_enpc.sv
// Self-checking bench for enpc: PHASES = 5, 1 and 3 instances driven in lockstep
// and compared every cycle against a counting model of enabled edges.
module tb_enpc;

  logic clock;
  logic resetN;
  logic enable;
  logic checking;

  int testsRun;
  int testsFailed;

  // Model state: enabled edges since the last reset, modulo PHASES.
  int cnt5;
  int cnt1;
  int cnt3;

  enpc_if bus5 ();
  enpc_if bus1 ();
  enpc_if bus3 ();

  assign bus5.en = enable;
  assign bus1.en = enable;
  assign bus3.en = enable;

  enpc #(.PHASES(5)) dut5 (.i_clock(clock), .i_reset_n(resetN), .bus(bus5));
  enpc #(.PHASES(1)) dut1 (.i_clock(clock), .i_reset_n(resetN), .bus(bus1));
  enpc #(.PHASES(3)) dut3 (.i_clock(clock), .i_reset_n(resetN), .bus(bus3));

  initial clock = 1'b0;
  always #10 clock = ~clock;

  task automatic checkOutput(input string name, input int actual, input int expected);
    testsRun++;
    if (actual != expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rstN);
    enable = en;
    resetN = rstN;
  endtask

  // Counts enabled edges until the P5 pulse shows up at a falling edge; 0 means it never came.
  task automatic waitPulse(output int edges);
    edges = 0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus5.set_en === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt5 = 0;
      cnt1 = 0;
      cnt3 = 0;
    end else if (enable) begin
      cnt5 = (cnt5 + 1) % 5;
      cnt1 = (cnt1 + 1) % 1;
      cnt3 = (cnt3 + 1) % 3;
    end
  end

  always @(negedge clock) begin
    if (checking) begin
      checkOutput("set_en P5", int'(bus5.set_en), (resetN && enable && cnt5 == 4) ? 1 : 0);
      checkOutput("set_en P1", int'(bus1.set_en), (resetN && enable && cnt1 == 0) ? 1 : 0);
      checkOutput("set_en P3", int'(bus3.set_en), (resetN && enable && cnt3 == 2) ? 1 : 0);
      checkOutput("phase P5", int'(dut5.r_phase), cnt5);
      checkOutput("phase P3", int'(dut3.r_phase), cnt3);
    end
  end

  initial begin
    int edges;
    int pulses;
    int lastPulse;
    testsRun    = 0;
    testsFailed = 0;
    checking    = 1'b1;
    cnt5 = 0;
    cnt1 = 0;
    cnt3 = 0;
    applyStimulus(1'b1, 1'b0);

    // Reset hold with enable high.
    repeat (4) @(posedge clock);
    #1;
    checkOutput("reset set_en P5", int'(bus5.set_en), 0);
    checkOutput("reset set_en P1", int'(bus1.set_en), 0);
    checkOutput("reset phase P5", int'(dut5.r_phase), 0);

    // Startup: release just after an edge, pulse only between edges 4 and 5.
    #1;
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("release set_en P1", int'(bus1.set_en), 1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      @(negedge clock);
      checkOutput($sformatf("startup edge %0d", k), int'(bus5.set_en), (k == 4) ? 1 : 0);
    end

    // Periodicity over 20 further cycles.
    pulses    = 0;
    lastPulse = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (bus5.set_en === 1'b1) begin
        if (lastPulse >= 0) checkOutput("pulse spacing", k - lastPulse, 5);
        lastPulse = k;
        pulses++;
      end
    end
    checkOutput("pulse count", pulses, 4);

    // Freeze at phase 4 for three edges.
    @(posedge clock);
    #2;
    checkOutput("freeze entry set_en", int'(bus5.set_en), 1);
    applyStimulus(1'b0, 1'b1);
    #1;
    checkOutput("freeze drop set_en", int'(bus5.set_en), 0);
    checkOutput("freeze set_en P1", int'(bus1.set_en), 0);
    repeat (3) @(posedge clock);
    #2;
    applyStimulus(1'b1, 1'b1);
    #1;
    checkOutput("freeze resume set_en", int'(bus5.set_en), 1);
    checkOutput("freeze held phase", int'(dut5.r_phase), 4);
    waitPulse(edges);
    checkOutput("pulse after freeze", edges, 5);

    // Asynchronous reset between edges while at phase 4.
    waitPulse(edges);
    checkOutput("pulse before reset", edges, 5);
    #3;
    resetN = 1'b0;
    #1;
    checkOutput("async set_en P5", int'(bus5.set_en), 0);
    checkOutput("async phase P5", int'(dut5.r_phase), 0);
    checkOutput("async set_en P1", int'(bus1.set_en), 0);
    repeat (2) @(posedge clock);
    #2;
    applyStimulus(1'b1, 1'b1);
    waitPulse(edges);
    checkOutput("pulse after reset", edges, 4);

    // Random enable and occasional reset, checked each cycle by the compare process.
    for (int k = 0; k < 400; k++) begin
      @(posedge clock);
      #2;
      applyStimulus(($urandom_range(0, 3) != 0), ($urandom_range(0, 29) != 0));
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clock);
        #3;
        resetN = 1'b0;
        #1;
        checkOutput("random async set_en P5", int'(bus5.set_en), 0);
      end
    end

    @(negedge clock);
    checking = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
